// File: rtl/adder_acc_if.sv
// adder_acc_if: request/response bundle for adder_acc.
//
// Request side  : in_valid, in_ready, a, b, op
// Response side : out_valid, out_ready, q, carry, ovf, count
//
// master : the block driving requests and consuming results (testbench/host)
// slave  : the adder_acc datapath itself
interface adder_acc_if #(
   parameter int unsigned WIDTH = 4
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [1:0]       op;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] q;
   logic             carry;
   logic             ovf;
   logic [7:0]       count;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, q, carry, ovf, count
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, q, carry, ovf, count
   );

endinterface

// File: rtl/adder_acc.sv
// adder_acc: registered add/subtract/accumulate unit with a one-deep output stage.
//
// Parameters
//   WIDTH : operand, result and accumulator width (2..32)
//   SAT   : 0 = wrap-around, 1 = unsigned saturation of q
//
// Ports
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : adder_acc_if slave modport
//             op 00 ADD q=a+b, 01 SUB q=a-b, 10 ACC acc+=a q=acc, 11 CLR acc=a q=a
//             carry is carry-out (ADD/ACC), borrow (SUB) or 0 (CLR)
//             ovf is signed overflow of the operation, 0 for CLR
//             count is the number of accepted requests (wraps at 8 bits)
module adder_acc #(
   parameter int unsigned WIDTH = 4,
   parameter bit          SAT   = 1'b0
) (
   input logic       clk,
   input logic       rst_n,
   adder_acc_if.slave bus
);

   localparam logic [1:0] OpAdd = 2'b00;
   localparam logic [1:0] OpSub = 2'b01;
   localparam logic [1:0] OpAcc = 2'b10;
   localparam logic [1:0] OpClr = 2'b11;

   localparam logic [WIDTH-1:0] AllOnes = '1;
   localparam logic [WIDTH-1:0] AllZero = '0;

   // Output stage and architectural state
   logic [WIDTH-1:0] q_q, q_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [7:0]       count_q, count_d;

   // Handshake
   logic in_ready;
   logic accept;
   logic consume;

   // Datapath, one bit wider than the operands so bit WIDTH is carry/borrow
   logic [WIDTH:0]   sum_ab;
   logic [WIDTH:0]   diff_ab;
   logic [WIDTH:0]   sum_acc;
   logic             a_msb;
   logic             b_msb;
   logic             acc_msb;

   logic [WIDTH-1:0] res_q;
   logic             res_carry;
   logic             res_ovf;
   logic             res_acc_wr;

   // The output register can take a new result whenever it is empty or being drained
   // in the same cycle, so a stalled consumer back-pressures the producer directly.
   assign in_ready = !valid_q || bus.out_ready;
   assign accept   = bus.in_valid && in_ready;
   assign consume  = valid_q && bus.out_ready;

   assign a_msb   = bus.a[WIDTH-1];
   assign b_msb   = bus.b[WIDTH-1];
   assign acc_msb = acc_q[WIDTH-1];

   always_comb begin
      sum_ab  = {1'b0, bus.a} + {1'b0, bus.b};
      diff_ab = {1'b0, bus.a} - {1'b0, bus.b};
      sum_acc = {1'b0, acc_q} + {1'b0, bus.a};
   end

   // Result selection. carry/ovf always describe the unclamped arithmetic; only q is
   // clamped when saturation is enabled.
   always_comb begin
      res_q      = AllZero;
      res_carry  = 1'b0;
      res_ovf    = 1'b0;
      res_acc_wr = 1'b0;

      unique case (bus.op)
         OpAdd: begin
            res_carry = sum_ab[WIDTH];
            res_ovf   = (a_msb == b_msb) && (sum_ab[WIDTH-1] != a_msb);
            res_q     = (SAT && res_carry) ? AllOnes : sum_ab[WIDTH-1:0];
         end
         OpSub: begin
            // Top bit of the widened difference is set exactly when a < b unsigned.
            res_carry = diff_ab[WIDTH];
            res_ovf   = (a_msb != b_msb) && (diff_ab[WIDTH-1] != a_msb);
            res_q     = (SAT && res_carry) ? AllZero : diff_ab[WIDTH-1:0];
         end
         OpAcc: begin
            res_carry  = sum_acc[WIDTH];
            res_ovf    = (acc_msb == a_msb) && (sum_acc[WIDTH-1] != acc_msb);
            res_q      = (SAT && res_carry) ? AllOnes : sum_acc[WIDTH-1:0];
            res_acc_wr = 1'b1;
         end
         OpClr: begin
            res_q      = bus.a;
            res_acc_wr = 1'b1;
         end
         default: begin
            res_q = AllZero;
         end
      endcase
   end

   // Next-state. The accumulator and counter follow accepts only, so they advance
   // independently of whether the previous result has been drained.
   always_comb begin
      q_d     = q_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      valid_d = valid_q;
      acc_d   = acc_q;
      count_d = count_q;

      if (accept) begin
         q_d     = res_q;
         carry_d = res_carry;
         ovf_d   = res_ovf;
         valid_d = 1'b1;
         count_d = count_q + 8'd1;
         if (res_acc_wr) begin
            acc_d = res_q;
         end
      end else if (consume) begin
         // q/carry/ovf keep their last value; only the valid flag drops.
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q     <= AllZero;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
         acc_q   <= AllZero;
         count_q <= 8'd0;
      end else begin
         q_q     <= q_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         valid_q <= valid_d;
         acc_q   <= acc_d;
         count_q <= count_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = valid_q;
   assign bus.q         = q_q;
   assign bus.carry     = carry_q;
   assign bus.ovf       = ovf_q;
   assign bus.count     = count_q;

endmodule

// File: tb/tb_adder_acc.sv
// tb_adder_acc: drives identical traffic into a wrap-around (SAT=0) and a saturating
// (SAT=1) adder_acc and compares both against a reference model through a scoreboard.
module tb_adder_acc;

   localparam int unsigned W = 4;
   localparam logic [1:0] ADD = 2'b00;
   localparam logic [1:0] SUB = 2'b01;
   localparam logic [1:0] ACC = 2'b10;
   localparam logic [1:0] CLR = 2'b11;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   always #5 clk = ~clk;

   adder_acc_if #(.WIDTH(W)) if0 ();
   adder_acc_if #(.WIDTH(W)) if1 ();

   adder_acc #(.WIDTH(W), .SAT(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   adder_acc #(.WIDTH(W), .SAT(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

   typedef struct packed {
      logic       v0;
      logic       v1;
      logic [3:0] q0;
      logic       c0;
      logic       o0;
      logic [3:0] q1;
      logic       c1;
      logic       o1;
      logic [7:0] n0;
      logic [7:0] n1;
   } obs_t;

   obs_t scb[$];
   obs_t last;
   int   acc0;
   int   acc1;
   int   cnt;
   logic cur_ordy;
   logic exp_rdy;
   int   n_tests;
   int   n_fail;

   // Reference arithmetic on plain integers: unsigned range checks for carry/borrow,
   // signed range checks for overflow.
   function automatic void calc(input logic [1:0] op, input int a, input int b, input int acc,
                                input bit sat, output int qv, output bit c, output bit o);
      int sa, sb2, sacc, r, s;
      sa   = (a >= 8) ? a - 16 : a;
      sb2  = (b >= 8) ? b - 16 : b;
      sacc = (acc >= 8) ? acc - 16 : acc;
      r = 0;
      s = 0;
      c = 1'b0;
      case (op)
         ADD: begin r = a + b;   c = (r > 15); s = sa + sb2;  end
         SUB: begin r = a - b;   c = (a < b);  s = sa - sb2;  end
         ACC: begin r = acc + a; c = (r > 15); s = sacc + sa; end
         default: begin r = a; c = 1'b0; s = 0; end
      endcase
      o  = (op != CLR) && (s > 7 || s < -8);
      qv = (r + 16) % 16;
      if (sat && c) qv = (op == SUB) ? 0 : 15;
   endfunction

   function automatic void push(input logic [1:0] op, input int a, input int b);
      obs_t e;
      int   qa, qb;
      bit   ca, oa, cb, ob;
      calc(op, a, b, acc0, 1'b0, qa, ca, oa);
      calc(op, a, b, acc1, 1'b1, qb, cb, ob);
      if (op == ACC || op == CLR) begin
         acc0 = qa;
         acc1 = qb;
      end
      cnt  = (cnt + 1) % 256;
      e.v0 = 1'b1;
      e.v1 = 1'b1;
      e.q0 = qa[3:0];
      e.c0 = ca;
      e.o0 = oa;
      e.q1 = qb[3:0];
      e.c1 = cb;
      e.o1 = ob;
      e.n0 = cnt[7:0];
      e.n1 = cnt[7:0];
      scb.push_back(e);
   endfunction

   function automatic obs_t expected_now();
      obs_t e;
      if (scb.size() > 0) begin
         e = scb[0];
      end else begin
         e    = last;
         e.v0 = 1'b0;
         e.v1 = 1'b0;
      end
      return e;
   endfunction

   function automatic obs_t observe();
      obs_t o;
      o.v0 = if0.out_valid;
      o.v1 = if1.out_valid;
      o.q0 = if0.q;
      o.c0 = if0.carry;
      o.o0 = if0.ovf;
      o.q1 = if1.q;
      o.c1 = if1.carry;
      o.o1 = if1.ovf;
      o.n0 = if0.count;
      o.n1 = if1.count;
      return o;
   endfunction

   function automatic void model_reset();
      scb.delete();
      last = '0;
      acc0 = 0;
      acc1 = 0;
      cnt  = 0;
   endfunction

   // Drive one cycle of stimulus into both DUTs, advance the model, and return #2 after
   // the rising edge with the inputs still applied.
   task automatic step(input logic iv, input logic [1:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic ordy);
      bit mv, accept, cons;
      if0.in_valid = iv;   if1.in_valid = iv;
      if0.op = op;         if1.op = op;
      if0.a = a;           if1.a = a;
      if0.b = b;           if1.b = b;
      if0.out_ready = ordy; if1.out_ready = ordy;
      cur_ordy = ordy;
      mv     = (scb.size() != 0);
      accept = iv && (!mv || ordy);
      cons   = mv && ordy;
      if (cons) last = scb.pop_front();
      if (accept) push(op, int'(a), int'(b));
      @(posedge clk);
      #2;
      exp_rdy = (scb.size() == 0) || cur_ordy;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      if0.in_valid = 1'b0;
      if1.in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      if0.in_valid = 1'b1;  if1.in_valid = 1'b1;
      if0.op = ADD;         if1.op = ADD;
      if0.a = 4'h1;         if1.a = 4'h1;
      if0.b = 4'h1;         if1.b = 4'h1;
      if0.out_ready = 1'b1; if1.out_ready = 1'b1;
      cur_ordy = 1'b1;
      model_reset();
      #1 rst_n = 1'b0;
      #1;
      n_tests++;
      if (observe() !== expected_now()) begin
         n_fail++;
         $display("FAIL reset_async: got %h want %h", observe(), expected_now());
      end
      // in_valid stays high across edges while reset is held: nothing may be accepted.
      @(posedge clk);
      @(posedge clk);
      #2;
      n_tests++;
      if (observe() !== expected_now()) begin
         n_fail++;
         $display("FAIL reset_hold: got %h want %h", observe(), expected_now());
      end
      n_tests++;
      if (if0.in_ready !== 1'b1 || if1.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_ready: got %b/%b want 1", if0.in_ready, if1.in_ready);
      end
      @(negedge clk);
      if0.in_valid = 1'b0;
      if1.in_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      #2;
      step(1'b0, ADD, 4'h0, 4'h0, 1'b1);
      n_tests++;
      if (observe() !== expected_now()) begin
         n_fail++;
         $display("FAIL reset_idle: got %h want %h", observe(), expected_now());
      end
   endtask

   task automatic test_arith();
      logic [9:0] vecs [8] = '{
         {ADD, 4'h5, 4'ha}, {ADD, 4'h7, 4'ha}, {SUB, 4'h1, 4'h2}, {SUB, 4'h7, 4'hf},
         {ADD, 4'h8, 4'h8}, {SUB, 4'h0, 4'h0}, {ADD, 4'hf, 4'h1}, {SUB, 4'h8, 4'h1}
      };
      logic [9:0] v;
      for (int i = 0; i < 8; i++) begin
         v = vecs[i];
         step(1'b1, v[9:8], v[7:4], v[3:0], 1'b1);
         n_tests++;
         if (observe() !== expected_now()) begin
            n_fail++;
            $display("FAIL arith[%0d]: got %h want %h", i, observe(), expected_now());
         end
      end
      step(1'b0, ADD, 4'h0, 4'h0, 1'b1);
      n_tests++;
      if (observe() !== expected_now()) begin
         n_fail++;
         $display("FAIL arith_drain: got %h want %h", observe(), expected_now());
      end
   endtask

   task automatic test_acc_sequence();
      logic [9:0] vecs [3] = '{{CLR, 4'h3, 4'h0}, {ACC, 4'h4, 4'h0}, {ACC, 4'h9, 4'h0}};
      logic [9:0] v;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         v = vecs[i];
         step(1'b1, v[9:8], v[7:4], v[3:0], 1'b1);
         n_tests++;
         if (observe() !== expected_now()) begin
            n_fail++;
            $display("FAIL acc_seq[%0d]: got %h want %h", i, observe(), expected_now());
         end
      end
   endtask

   task automatic test_backpressure();
      step(1'b1, ADD, 4'h2, 4'h3, 1'b0);
      n_tests++;
      if (observe() !== expected_now()) begin
         n_fail++;
         $display("FAIL bp_first: got %h want %h", observe(), expected_now());
      end
      for (int i = 0; i < 5; i++) begin
         step(1'b1, SUB, 4'h9, 4'h4, 1'b0);
         n_tests++;
         if (observe() !== expected_now()) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: got %h want %h", i, observe(), expected_now());
         end
         n_tests++;
         if (if0.in_ready !== exp_rdy || if1.in_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL bp_in_ready[%0d]: got %b/%b want %b", i, if0.in_ready,
                     if1.in_ready, exp_rdy);
         end
      end
      // Release with the request still pending: next result must land with no gap.
      step(1'b1, SUB, 4'h9, 4'h4, 1'b1);
      n_tests++;
      if (observe() !== expected_now()) begin
         n_fail++;
         $display("FAIL bp_release: got %h want %h", observe(), expected_now());
      end
      step(1'b0, ADD, 4'h0, 4'h0, 1'b1);
      n_tests++;
      if (observe() !== expected_now()) begin
         n_fail++;
         $display("FAIL bp_drain: got %h want %h", observe(), expected_now());
      end
   endtask

   task automatic test_reset_midflight();
      do_reset();
      step(1'b1, CLR, 4'h3, 4'h0, 1'b1);
      step(1'b1, ACC, 4'h4, 4'h0, 1'b1);
      step(1'b0, ADD, 4'h0, 4'h0, 1'b0);
      n_tests++;
      if (observe() !== expected_now()) begin
         n_fail++;
         $display("FAIL midflight_pre: got %h want %h", observe(), expected_now());
      end
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      n_tests++;
      if (observe() !== expected_now()) begin
         n_fail++;
         $display("FAIL midflight_clear: got %h want %h", observe(), expected_now());
      end
      n_tests++;
      if (if0.in_ready !== 1'b1 || if1.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL midflight_in_ready: got %b/%b want 1", if0.in_ready, if1.in_ready);
      end
      #1 rst_n = 1'b1;
      step(1'b1, ACC, 4'h2, 4'h0, 1'b1);
      n_tests++;
      if (observe() !== expected_now()) begin
         n_fail++;
         $display("FAIL midflight_acc: got %h want %h", observe(), expected_now());
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         step(1'($urandom_range(0, 1)), 2'($urandom), 4'($urandom), 4'($urandom),
              ($urandom_range(0, 3) != 0));
         n_tests++;
         if (observe() !== expected_now()) begin
            n_fail++;
            $display("FAIL random[%0d]: got %h want %h", i, observe(), expected_now());
         end
         n_tests++;
         if (if0.in_ready !== exp_rdy || if1.in_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL random_in_ready[%0d]: got %b/%b want %b", i, if0.in_ready,
                     if1.in_ready, exp_rdy);
         end
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      exp_rdy = 1'b1;
      test_reset();
      test_arith();
      test_acc_sequence();
      test_backpressure();
      test_reset_midflight();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
